// File: rtl/mdr_mem_pkg.sv
// Shared definitions for the MDR memory stage: default widths, wait-counter
// width and the transaction state encoding.
package mdr_mem_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int ADDR_W_DEF  = 9;
   localparam int TIMEOUT_DEF = 15;
   localparam int CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } state_e;

endpackage

// File: rtl/mdr_mem_unit_if.sv
// Single-word req/ack memory port between the MDR stage (master) and the
// memory (slave).
interface mdr_mem_unit_if
   import mdr_mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mdr_mem_unit_wait_ctr.sv
// Wait counter for memory acknowledge: clear, increment, and a flag that is
// high when the count has reached TIMEOUT-1.
module mem_wait_ctr
   import mdr_mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clock,
   input  logic clear,
   input  logic ctr_clr,
   input  logic ctr_inc,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ctr_clr) begin
         cnt_d = '0;
      end else if (ctr_inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mdr_mem_unit.sv
// Memory Data Register stage: holds the MDR feeding the bus mux and runs
// single-word read/write transactions with a bounded wait for mem_ack.
module mdr_mem_unit
   import mdr_mem_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              mdr_in,
   input  logic [ADDR_W-1:0] mar_addr,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              done,
   output logic              mem_err,
   output logic              cmd_err,
   mdr_mem_unit_if.master    mem
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mem_err_q, mem_err_d;
   logic              cmd_err_q, cmd_err_d;
   logic              ctr_clr, ctr_inc, ctr_tc;

   mem_wait_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_ctr (
      .clock   (clock),
      .clear   (clear),
      .ctr_clr (ctr_clr),
      .ctr_inc (ctr_inc),
      .tc      (ctr_tc)
   );

   always_comb begin
      state_d     = state_q;
      mdr_d       = mdr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      busy_d      = busy_q;
      mem_err_d   = mem_err_q;
      done_d      = 1'b0;
      cmd_err_d   = 1'b0;
      ctr_clr     = 1'b1;
      ctr_inc     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mdr_in) begin
               mdr_d = bus_in;
            end
            if (read && write) begin
               cmd_err_d = 1'b1;
            end else if (read) begin
               mem_addr_d = mar_addr;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               busy_d     = 1'b1;
               mem_err_d  = 1'b0;
               state_d    = RD_WAIT;
            end else if (write) begin
               // A same-cycle MDR load is forwarded straight into the write data.
               mem_addr_d  = mar_addr;
               mem_wdata_d = mdr_in ? bus_in : mdr_q;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               busy_d      = 1'b1;
               mem_err_d   = 1'b0;
               state_d     = WR_WAIT;
            end
         end

         RD_WAIT, WR_WAIT: begin
            ctr_clr = 1'b0;
            // Ack takes priority over an expiring wait on the same edge.
            if (mem.mem_ack) begin
               if (state_q == RD_WAIT) begin
                  mdr_d = mem.mem_rdata;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               ctr_clr   = 1'b1;
               state_d   = IDLE;
            end else if (ctr_tc) begin
               mem_req_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               mem_err_d = 1'b1;
               ctr_clr   = 1'b1;
               state_d   = IDLE;
            end else begin
               ctr_inc = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q     <= IDLE;
         mdr_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_err_q   <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mdr_q       <= mdr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_err_q   <= mem_err_d;
         cmd_err_q   <= cmd_err_d;
      end
   end

   assign mdr_out       = mdr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign mem_err       = mem_err_q;
   assign cmd_err       = cmd_err_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mdr_mem_unit.sv
// Directed bench for mdr_mem_unit: expected MDR values are queued when a
// command is issued and compared when done pulses.
module tb_mdr_mem_unit;

   logic        clock = 1'b0;
   logic        clear;
   logic [31:0] bus_in;
   logic        mdr_in;
   logic [8:0]  mar_addr;
   logic        read;
   logic        write;
   logic [31:0] mdr_out;
   logic        busy;
   logic        done;
   logic        mem_err;
   logic        cmd_err;

   int checks   = 0;
   int failures = 0;
   int req_cycles;
   logic [31:0] exp_q[$];

   mdr_mem_unit_if mem_if ();

   mdr_mem_unit dut (
      .clock    (clock),
      .clear    (clear),
      .bus_in   (bus_in),
      .mdr_in   (mdr_in),
      .mar_addr (mar_addr),
      .read     (read),
      .write    (write),
      .mdr_out  (mdr_out),
      .busy     (busy),
      .done     (done),
      .mem_err  (mem_err),
      .cmd_err  (cmd_err),
      .mem      (mem_if)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one command edge; inputs are removed right after the edge.
   task automatic issue(input logic rd, input logic wr, input logic [8:0] addr);
      read     = rd;
      write    = wr;
      mar_addr = addr;
      tick();
      read   = 1'b0;
      write  = 1'b0;
      mdr_in = 1'b0;
   endtask

   // Acks after ack_edges edges (0 = never), counts mem_req cycles and
   // compares the scoreboard entry against mdr_out when done appears.
   task automatic run_txn(input string tag, input int ack_edges, input logic [31:0] rdata,
                          input bit inject, output int reqs);
      bit got = 0;
      reqs = mem_if.mem_req ? 1 : 0;
      for (int i = 1; i <= 60 && !got; i++) begin
         mem_if.mem_ack   = (i == ack_edges);
         mem_if.mem_rdata = (i == ack_edges) ? rdata : 32'hDEAD_BEEF;
         if (inject && i == 1) begin
            write  = 1'b1;
            mdr_in = 1'b1;
            bus_in = 32'd20;
         end
         tick();
         mem_if.mem_ack = 1'b0;
         write  = 1'b0;
         mdr_in = 1'b0;
         if (inject && i == 1) begin
            check({tag, "_busy_cmd_err"}, {31'd0, cmd_err}, 32'd0);
            check({tag, "_busy_we"}, {31'd0, mem_if.mem_we}, 32'd0);
         end
         if (mem_if.mem_req) reqs++;
         if (done) got = 1;
      end
      if (!got) begin
         check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
      end else if (exp_q.size() == 0) begin
         check({tag, "_sb_entry"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_mdr"}, mdr_out, exp_q.pop_front());
         check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      clear            = 1'b0;
      bus_in           = '0;
      mdr_in           = 1'b0;
      mar_addr         = '0;
      read             = 1'b0;
      write            = 1'b0;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = '0;
      #12;
      check("rst_mdr", mdr_out, 32'd0);
      check("rst_req", {31'd0, mem_if.mem_req}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_err", {30'd0, mem_err, cmd_err}, 32'd0);
      clear = 1'b1;

      // MDR load from the bus
      bus_in = 32'h0000_00F3;
      mdr_in = 1'b1;
      tick();
      mdr_in = 1'b0;
      check("load_mdr", mdr_out, 32'hF3);
      check("load_req", {31'd0, mem_if.mem_req}, 32'd0);
      check("load_flags", {29'd0, busy, done, cmd_err}, 32'd0);

      // Read acked three edges after the command
      issue(1'b1, 1'b0, 9'd20);
      check("rd_req", {31'd0, mem_if.mem_req}, 32'd1);
      check("rd_we", {31'd0, mem_if.mem_we}, 32'd0);
      check("rd_addr", {23'd0, mem_if.mem_addr}, 32'd20);
      check("rd_busy", {31'd0, busy}, 32'd1);
      exp_q.push_back(32'd145);
      run_txn("rd3", 3, 32'd145, 1'b0, req_cycles);
      check("rd3_req_cycles", req_cycles, 32'd3);
      tick();
      check("rd3_done_once", {31'd0, done}, 32'd0);

      // Write with same-cycle MDR load, acked after one edge
      bus_in = 32'd100;
      mdr_in = 1'b1;
      issue(1'b0, 1'b1, 9'd5);
      check("wr_we", {31'd0, mem_if.mem_we}, 32'd1);
      check("wr_wdata", mem_if.mem_wdata, 32'd100);
      check("wr_addr", {23'd0, mem_if.mem_addr}, 32'd5);
      check("wr_mdr", mdr_out, 32'd100);
      exp_q.push_back(32'd100);
      run_txn("wr1", 1, 32'h5555_AAAA, 1'b0, req_cycles);
      check("wr1_req_cycles", req_cycles, 32'd1);
      check("wr1_we_after", {31'd0, mem_if.mem_we}, 32'd0);
      tick();
      check("wr1_done_once", {31'd0, done}, 32'd0);

      // Read with no ack times out; MDR keeps its value
      issue(1'b1, 1'b0, 9'd7);
      exp_q.push_back(32'd100);
      run_txn("tmo", 0, 32'd0, 1'b0, req_cycles);
      check("tmo_req_cycles", req_cycles, 32'd15);
      check("tmo_err", {31'd0, mem_err}, 32'd1);
      tick();
      check("tmo_err_sticky", {31'd0, mem_err}, 32'd1);

      // Next accepted read clears the error
      issue(1'b1, 1'b0, 9'd8);
      check("rd_err_cleared", {31'd0, mem_err}, 32'd0);
      exp_q.push_back(32'h1234_5678);
      run_txn("rd1", 1, 32'h1234_5678, 1'b0, req_cycles);
      check("rd1_req_cycles", req_cycles, 32'd1);

      // Illegal command
      tick();
      issue(1'b1, 1'b1, 9'd3);
      check("cmd_err_pulse", {31'd0, cmd_err}, 32'd1);
      check("cmd_err_no_req", {31'd0, mem_if.mem_req}, 32'd0);
      check("cmd_err_no_busy", {31'd0, busy}, 32'd0);
      tick();
      check("cmd_err_one_cycle", {31'd0, cmd_err}, 32'd0);

      // Strobes while busy are ignored
      issue(1'b1, 1'b0, 9'd9);
      exp_q.push_back(32'd77);
      run_txn("ign", 3, 32'd77, 1'b1, req_cycles);
      check("ign_req_cycles", req_cycles, 32'd3);
      check("ign_wdata", mem_if.mem_wdata, 32'd100);

      // Asynchronous reset mid-read
      tick();
      issue(1'b1, 1'b0, 9'd11);
      tick();
      tick();
      #1;
      clear = 1'b0;
      #1;
      check("arst_req", {31'd0, mem_if.mem_req}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_mdr", mdr_out, 32'd0);
      exp_q.delete();
      tick();
      clear = 1'b1;
      tick();
      issue(1'b1, 1'b0, 9'd12);
      check("post_rst_addr", {23'd0, mem_if.mem_addr}, 32'd12);
      exp_q.push_back(32'h0000_CAFE);
      run_txn("post_rst", 1, 32'h0000_CAFE, 1'b0, req_cycles);
      check("post_rst_req_cycles", req_cycles, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdr_mem_unit.md
Name: mdr_mem_unit

Overview:
- Memory Data Register stage that sits directly upstream of the datapath bus multiplexer.
- Its registered output mdr_out drives the bus mux MDR input.
- Captures bus data on mdr_in. Runs single-word read and write transactions against a req/ack memory port, with a bounded wait (timeout) and error reporting.
- Control-sequencer strobes drive it; address comes from the MAR.

Parameters:
- DATA_W, 32, data/bus width
- ADDR_W, 9, memory address width
- TIMEOUT, 15, maximum wait edges for mem_ack before abort (1..255)

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- bus_in  in  DATA_W  bus mux output
- mdr_in  in  1  load MDR from bus_in
- mar_addr  in  ADDR_W  address from MAR
- read  in  1  start memory read strobe
- write  in  1  start memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion
- mdr_out  out  DATA_W  MDR contents to bus mux
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- mem_err  out  1  sticky timeout flag
- cmd_err  out  1  one-cycle illegal-command pulse

Behaviour:
- Reset (clear=0, asynchronous): state IDLE; mdr_out, mem_addr, mem_wdata = 0; mem_req, mem_we, busy, done, mem_err, cmd_err = 0; wait counter = 0. Asserting clear mid-transaction drops mem_req immediately, and the transaction is lost.
- All outputs are registered. mdr_out equals the MDR register at all times.
- States: IDLE, RD_WAIT, WR_WAIT.
- In IDLE, at each edge:
  - mdr_in=1: MDR <= bus_in.
  - read=1, write=0: mem_addr <= mar_addr; mem_req <= 1; mem_we <= 0; busy <= 1; mem_err <= 0; go to RD_WAIT.
  - write=1, read=0: mem_addr <= mar_addr; mem_wdata <= (mdr_in ? bus_in : MDR), i.e. same-cycle load is forwarded; mem_req <= 1; mem_we <= 1; busy <= 1; mem_err <= 0; go to WR_WAIT.
  - read=1 and write=1: no transaction; cmd_err pulses for 1 cycle; the mdr_in load still occurs.
  - read with mdr_in in the same cycle: the load occurs, then is overwritten by the read data.
- In RD_WAIT / WR_WAIT, at each edge:
  - mem_ack=1: RD_WAIT sets MDR <= mem_rdata; WR_WAIT leaves MDR unchanged. Then mem_req <= 0, mem_we <= 0, busy <= 0, done <= 1, counter <= 0, go to IDLE.
  - mem_ack=0 and counter = TIMEOUT-1: abort. mem_req <= 0, busy <= 0, done <= 1, mem_err <= 1, MDR unchanged, go to IDLE.
  - Otherwise: counter increments.
  - If ack arrives on the timeout edge, ack wins.
- Latency:
  - Command sampled at edge k, so mem_req=1 from k.
  - Ack sampled at edge k+m (m ≥ 1), so mdr_out is updated and done=1 during the cycle after k+m.
  - Minimum read latency is 2 edges.
- While busy, read, write and mdr_in are ignored (no cmd_err).
- done is high during the first IDLE cycle. A new command is accepted in that cycle.
- mem_err stays high until the next accepted command.
- mem_ack in IDLE is ignored.

Decomposition:
- Shared package mdr_mem_pkg: state encoding localparams (IDLE, RD_WAIT, WR_WAIT) and the default width constants.
- One sub-module, mem_wait_ctr: clear / increment / terminal-count flag, parameterised by TIMEOUT, with the same clock and reset.

Test Plan:
- Reset, then mdr_in=1 with bus_in=32'h0000_00F3 → mdr_out=32'hF3 the next cycle; all handshake outputs remain 0.
- read with mar_addr=9'd20; memory returns 32'd145 with ack 3 edges later → mem_req high for exactly 3 cycles, mem_we=0, mdr_out=145, done pulses once, busy low afterwards.
- mdr_in=1, bus_in=32'd100 and write=1 in the same cycle, mar_addr=9'd5, ack after 1 edge → mem_wdata=100, mem_we=1, mem_addr=5, mdr_out=100, done pulses once.
- read with no ack, TIMEOUT=15 → mem_req drops after exactly 15 cycles, mem_err=1, mdr_out unchanged. A following read acked after 1 edge clears mem_err and loads data.
- read=write=1 in IDLE → cmd_err pulse, no mem_req. Then, during an active read, pulse write and mdr_in with bus_in=32'd20 → both ignored, and the read completes normally.
- Start a read, deassert clear 2 cycles later → mem_req, busy and mdr_out are 0 immediately. After release, a new read (ack after 1 edge) completes normally.
